// File: rtl/prog_loader.sv
// Byte-stream program loader: packs byte pairs into 16-bit words, writes them to the
// instruction SRAM, verifies a trailing XOR checksum and only then releases the CPU.
module prog_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    output logic              in_ready_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_sel_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LO, S_HI, S_WR, S_CSUM, S_DONE, S_ERR
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [7:0]          lo_q, lo_d;
    logic [7:0]          xor_q, xor_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ready;
    logic                xfer;

    assign xfer = in_valid_i & ready;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lo_q    <= '0;
            xor_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            xor_q   <= xor_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // NOTE: every signal gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        xor_d   = xor_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    cnt_d   = '0;
                    xor_d   = '0;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    lo_d    = in_data_i;
                    xor_d   = xor_q ^ in_data_i;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (xfer) begin
                    xor_d   = xor_q ^ in_data_i;
                    wdata_d = {in_data_i, lo_q};
                    addr_d  = cnt_q;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (addr_q == '1) ? S_CSUM : S_LO;
            end
            S_CSUM: begin
                if (xfer) state_d = (in_data_i == xor_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // All status outputs are plain decodes of the state register, hence glitch-free levels.
    always_comb begin
        ready      = (state_q == S_LO) || (state_q == S_HI) || (state_q == S_CSUM);
        busy_o     = (state_q == S_LO) || (state_q == S_HI) || (state_q == S_WR) ||
                     (state_q == S_CSUM);
        in_ready_o = ready;
        mem_we_o   = (state_q == S_WR);
        mem_sel_o  = busy_o;
        cpu_hold_o = (state_q != S_DONE);
        done_o     = (state_q == S_DONE);
        err_o      = (state_q == S_ERR);
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a stream-level model predicts every SRAM write
// and the load verdict; a negedge monitor compares the write port every cycle.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic [7:0]  in_data_i = 8'h00;
    logic        in_ready_o, mem_we_o, mem_sel_o, cpu_hold_o, busy_o, done_o, err_o;
    logic [3:0]  mem_addr_o;
    logic [15:0] mem_wdata_o;

    prog_loader #(.ADDR_W(4), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .in_valid_i(in_valid_i),
        .in_data_i(in_data_i), .in_ready_o(in_ready_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
        .cpu_hold_o(cpu_hold_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    wr_t         exp_q[$];
    logic [15:0] sram [16];
    logic [7:0]  stream [33];
    logic        we_prev = 1'b0;
    time         t_start;
    bit          exp_ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write-port monitor: every strobe must match the next predicted word, strobes are single-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            we_prev = 1'b0;
        end else begin
            check("we_pulse_width", {31'd0, we_prev & mem_we_o}, 32'd0);
            check("sel_tracks_busy", {31'd0, mem_sel_o}, {31'd0, busy_o});
            check("ready_implies_busy", {31'd0, in_ready_o & ~busy_o}, 32'd0);
            if (mem_we_o) begin
                check("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("write_addr", {28'd0, mem_addr_o}, {28'd0, w.addr});
                    check("write_data", {16'd0, mem_wdata_o}, {16'd0, w.data});
                end
                sram[mem_addr_o] = mem_wdata_o;
            end
            we_prev = mem_we_o;
        end
    end

    // Model: the stream alone determines the writes and whether the load must succeed.
    task automatic predict();
        logic [7:0] x;
        x = 8'h00;
        exp_q.delete();
        for (int k = 0; k < 16; k++) begin
            wr_t w;
            w.addr = 4'(k);
            w.data = {stream[2*k+1], stream[2*k]};
            exp_q.push_back(w);
            x = x ^ stream[2*k] ^ stream[2*k+1];
        end
        exp_ok = (x == stream[32]);
        for (int k = 0; k < 16; k++) sram[k] = 16'hDEAD;
    endtask

    task automatic do_start();
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        t_start = $time;
        #1 start_i = 1'b0;
        check("start_busy", {31'd0, busy_o}, 32'd1);
        check("start_done_clr", {31'd0, done_o}, 32'd0);
        check("start_err_clr", {31'd0, err_o}, 32'd0);
        check("start_hold", {31'd0, cpu_hold_o}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse_start);
        int n;
        n = 0;
        repeat (gap) begin
            @(negedge clk);
            in_valid_i = 1'b0;
        end
        @(negedge clk);
        in_valid_i = 1'b1;
        in_data_i  = b;
        start_i    = pulse_start;
        while (!in_ready_o && n < 50) begin
            @(negedge clk);
            start_i = 1'b0;
            n++;
        end
        check("byte_accepted_in_time", {31'd0, n < 50}, 32'd1);
        @(posedge clk);
        #1;
        start_i    = 1'b0;
        in_valid_i = 1'b0;
    endtask

    task automatic run_load(input int max_gap, input int pulse_idx);
        predict();
        do_start();
        for (int i = 0; i < 33; i++)
            send_byte(stream[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, i == pulse_idx);
        @(negedge clk);
        check("end_done", {31'd0, done_o}, {31'd0, exp_ok});
        check("end_err", {31'd0, err_o}, {31'd0, !exp_ok});
        check("end_hold", {31'd0, cpu_hold_o}, {31'd0, !exp_ok});
        check("end_sel", {31'd0, mem_sel_o}, 32'd0);
        check("end_busy", {31'd0, busy_o}, 32'd0);
        check("end_ready", {31'd0, in_ready_o}, 32'd0);
        check("all_writes_seen", exp_q.size(), 32'd0);
    endtask

    task automatic fill_good(input logic [7:0] csum);
        for (int k = 0; k < 16; k++) begin
            stream[2*k]   = 8'(k);
            stream[2*k+1] = 8'h01;
        end
        stream[32] = csum;
    endtask

    task automatic check_sram_good();
        for (int k = 0; k < 16; k++)
            check("sram_word", {16'd0, sram[k]}, 32'h0100 + k);
    endtask

    initial begin
        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", {31'd0, cpu_hold_o}, 32'd1);
        check("rst_we", {31'd0, mem_we_o}, 32'd0);
        check("rst_addr", {28'd0, mem_addr_o}, 32'd0);
        check("rst_wdata", {16'd0, mem_wdata_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_hold", {31'd0, cpu_hold_o}, 32'd1);
        check("idle_ready", {31'd0, in_ready_o}, 32'd0);
        check("idle_done", {31'd0, done_o}, 32'd0);
        check("idle_err", {31'd0, err_o}, 32'd0);
        check("idle_busy", {31'd0, busy_o}, 32'd0);

        // Good load, continuous valid: 49 cycles from the start edge to DONE
        fill_good(8'h00);
        run_load(0, -1);
        check("good_latency", 32'(($time - t_start - 2) / 10), 32'd49);
        check_sram_good();
        check("pin_word0", {16'd0, sram[0]}, 32'h0100);
        check("pin_word15", {16'd0, sram[15]}, 32'h010F);

        // Bad checksum: all writes happen, then ERR with the CPU still held
        fill_good(8'hFF);
        run_load(0, -1);
        check_sram_good();
        check("pin_bad_err", {31'd0, err_o}, 32'd1);

        // Reload after ERR with 0xA5 words; a mid-load start pulse is ignored
        for (int i = 0; i < 32; i++) stream[i] = 8'hA5;
        stream[32] = 8'h00;
        run_load(0, 15);
        for (int k = 0; k < 16; k++) check("a5_word", {16'd0, sram[k]}, 32'hA5A5);
        check("pin_a5_done", {31'd0, done_o}, 32'd1);

        // Stalls of 0-5 cycles plus an ignored start on a transfer cycle
        fill_good(8'h00);
        run_load(5, 20);
        check_sram_good();

        // Async reset mid-load, right after word 5 is accepted
        predict();
        do_start();
        for (int i = 0; i < 12; i++) send_byte(stream[i], 0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_hold", {31'd0, cpu_hold_o}, 32'd1);
        check("midrst_ready", {31'd0, in_ready_o}, 32'd0);
        check("midrst_we", {31'd0, mem_we_o}, 32'd0);
        check("midrst_sel", {31'd0, mem_sel_o}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_hold", {31'd0, cpu_hold_o}, 32'd1);
        run_load(0, -1);
        check_sram_good();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
